mult_div_seq: RTL

//  Sequential multiply/divide unit for the multicycle CPU; executes mult/div and owns the HI/LO registers.

---
 rtl/mult_div_seq.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/mult_div_seq.sv
// rtl/mult_div_seq.sv - sequential mult/div unit owning HI/LO; optional MULTDIV_UNSIGNED_EN adds multu/divu
module mult_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
`ifdef MULTDIV_UNSIGNED_EN
    input  logic             op_unsigned,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 op_q, op_d;
    logic                 neg_q, neg_d;       // result sign differs from magnitude
    logic                 sgn_a_q, sgn_a_d;   // remainder follows dividend sign
    logic [2*WIDTH-1:0]   acc_q, acc_d;       // {hi half, lo half} working register
    logic [WIDTH-1:0]     opb_q, opb_d;       // |a| for mult (addend), |b| for div (divisor)
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 divz_q, divz_d;

    logic                 is_signed;
    logic                 sign_a_in, sign_b_in;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic                 accept;

    logic [WIDTH:0]       add_x, add_y;
    logic                 add_cin;
    logic [WIDTH+1:0]     add_sum;
    logic [2*WIDTH-1:0]   fix_prod;
    logic [WIDTH-1:0]     fix_quo, fix_rem;

`ifdef MULTDIV_UNSIGNED_EN
    assign is_signed = ~op_unsigned;
`else
    assign is_signed = 1'b1;
`endif

    assign sign_a_in = a[WIDTH-1] & is_signed;
    assign sign_b_in = b[WIDTH-1] & is_signed;
    // Magnitude of the most negative value is its own unsigned bit pattern
    assign mag_a     = sign_a_in ? (~a + 1'b1) : a;
    assign mag_b     = sign_b_in ? (~b + 1'b1) : b;
    assign accept    = start & ((state_q == S_IDLE) | (state_q == S_DONE));

    // Shared adder: accumulate for mult, trial subtract (carry-out = no borrow) for div
    always_comb begin
        add_x   = '0;
        add_y   = '0;
        add_cin = 1'b0;
        if (!op_q) begin
            add_x = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
            add_y = acc_q[0] ? {1'b0, opb_q} : '0;
        end else begin
            add_x   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
            add_y   = ~{1'b0, opb_q};
            add_cin = 1'b1;
        end
        add_sum = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH+1){1'b0}}, add_cin};
    end

    // Next-state, datapath update and sign fix-up
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        sgn_a_d  = sgn_a_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        divz_d   = 1'b0;
        fix_prod = neg_q ? (~acc_q + 1'b1) : acc_q;
        fix_quo  = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
        fix_rem  = sgn_a_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    if (op && (b == '0)) begin
                        // Divide by zero: report at once, leave hi/lo untouched
                        state_d = S_DONE;
                        divz_d  = 1'b1;
                    end else begin
                        state_d = S_CALC;
                        cnt_d   = CW'(WIDTH - 1);
                        op_d    = op;
                        neg_d   = sign_a_in ^ sign_b_in;
                        sgn_a_d = sign_a_in;
                        if (!op) begin
                            acc_d = {{WIDTH{1'b0}}, mag_b};
                            opb_d = mag_a;
                        end else begin
                            acc_d = {{WIDTH{1'b0}}, mag_a};
                            opb_d = mag_b;
                        end
                    end
                end
            end
            S_CALC: begin
                if (!op_q) begin
                    acc_d = {add_sum[WIDTH:0], acc_q[WIDTH-1:1]};
                end else if (add_sum[WIDTH+1]) begin
                    acc_d = {add_sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (!op_q) begin
                    hi_d = fix_prod[2*WIDTH-1:WIDTH];
                    lo_d = fix_prod[WIDTH-1:0];
                end else begin
                    hi_d = fix_rem;
                    lo_d = fix_quo;
                end
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            neg_q   <= 1'b0;
            sgn_a_q <= 1'b0;
            acc_q   <= '0;
            opb_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            divz_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            sgn_a_q <= sgn_a_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            divz_q  <= divz_d;
        end
    end

    assign busy     = (state_q == S_CALC) | (state_q == S_FIX);
    assign done     = (state_q == S_DONE);
    assign div_zero = divz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule
